// File: rtl/vector_reg_file_stream.sv
// -----------------------------------------------------------------------------
// vector_reg_file_stream
// Vector register file: NUM_REG registers of NUM_ELE elements, DATA_WIDTH bits
// per element. Two independent registered read ports and one byte-enabled write
// port. A background sweep can zero one whole register, one element per cycle.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   rd_en_x, rd_reg_x, rd_ele_x read request for port x (a/b), 1-cycle latency
//   rd_data_x, rd_valid_x      registered read data and qualifier
//   wr_valid, wr_ready         write handshake (ready only while no sweep runs)
//   wr_reg, wr_ele, wr_data    write address and data
//   wr_be                      per-byte write enable
//   clr_req, clr_reg           start a zeroing sweep of clr_reg
//   clr_busy, clr_done         sweep in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module vector_reg_file_stream #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REG    = 8,
   parameter int NUM_ELE    = 32,
   parameter int REG_AW     = 5,
   parameter int ELE_AW     = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    rd_en_a,
   input  logic [REG_AW-1:0]       rd_reg_a,
   input  logic [ELE_AW-1:0]       rd_ele_a,
   output logic [DATA_WIDTH-1:0]   rd_data_a,
   output logic                    rd_valid_a,
   input  logic                    rd_en_b,
   input  logic [REG_AW-1:0]       rd_reg_b,
   input  logic [ELE_AW-1:0]       rd_ele_b,
   output logic [DATA_WIDTH-1:0]   rd_data_b,
   output logic                    rd_valid_b,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [REG_AW-1:0]       wr_reg,
   input  logic [ELE_AW-1:0]       wr_ele,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic                    clr_req,
   input  logic [REG_AW-1:0]       clr_reg,
   output logic                    clr_busy,
   output logic                    clr_done
);

   localparam int NUM_BYTES = DATA_WIDTH / 8;
   localparam int DEPTH     = NUM_REG * NUM_ELE;
   localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Flat element index: register-major, element-minor.
   function automatic logic [IDX_W-1:0] f_idx(input logic [REG_AW-1:0] reg_i,
                                              input logic [ELE_AW-1:0] ele_i);
      int unsigned v;
      v = 32'(reg_i) * 32'(NUM_ELE) + 32'(ele_i);
      return v[IDX_W-1:0];
   endfunction

   // Address range check; out-of-range accesses never touch storage.
   function automatic logic f_in_range(input logic [REG_AW-1:0] reg_i,
                                       input logic [ELE_AW-1:0] ele_i);
      return (32'(reg_i) < 32'(NUM_REG)) && (32'(ele_i) < 32'(NUM_ELE));
   endfunction

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   state_t                r_state;
   logic [ELE_AW-1:0]     r_cnt;
   logic [REG_AW-1:0]     r_clr_reg;
   logic                  r_clr_busy;
   logic                  r_clr_done;
   logic                  r_wr_ready;
   logic [DATA_WIDTH-1:0] r_rd_data_a;
   logic [DATA_WIDTH-1:0] r_rd_data_b;
   logic                  r_rd_valid_a;
   logic                  r_rd_valid_b;

   logic                  w_wr_fire;
   logic                  w_wr_in;
   logic [IDX_W-1:0]      w_wr_idx;
   logic                  w_clr_in;
   logic [IDX_W-1:0]      w_clr_idx;
   logic                  w_rd_in_a;
   logic                  w_rd_in_b;
   logic [IDX_W-1:0]      w_rd_idx_a;
   logic [IDX_W-1:0]      w_rd_idx_b;

   assign w_wr_fire  = wr_valid && r_wr_ready;
   assign w_wr_in    = f_in_range(wr_reg, wr_ele);
   assign w_wr_idx   = f_idx(wr_reg, wr_ele);
   assign w_clr_in   = f_in_range(r_clr_reg, r_cnt);
   assign w_clr_idx  = f_idx(r_clr_reg, r_cnt);
   assign w_rd_in_a  = f_in_range(rd_reg_a, rd_ele_a);
   assign w_rd_idx_a = f_idx(rd_reg_a, rd_ele_a);
   assign w_rd_in_b  = f_in_range(rd_reg_b, rd_ele_b);
   assign w_rd_idx_b = f_idx(rd_reg_b, rd_ele_b);

   // Storage: user writes happen only in IDLE and sweep writes only in CLEAR,
   // so the two never collide on one edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_fire && w_wr_in) begin
         for (int k = 0; k < NUM_BYTES; k++) begin
            if (wr_be[k]) begin
               r_mem[w_wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
         end
      end else if ((r_state == S_CLEAR) && w_clr_in) begin
         r_mem[w_clr_idx] <= '0;
      end
   end

   // Read ports: sample the array before this edge's write lands (read-first).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_data_a  <= '0;
         r_rd_data_b  <= '0;
         r_rd_valid_a <= 1'b0;
         r_rd_valid_b <= 1'b0;
      end else begin
         r_rd_valid_a <= rd_en_a;
         r_rd_valid_b <= rd_en_b;
         if (rd_en_a) begin
            r_rd_data_a <= w_rd_in_a ? r_mem[w_rd_idx_a] : '0;
         end
         if (rd_en_b) begin
            r_rd_data_b <= w_rd_in_b ? r_mem[w_rd_idx_b] : '0;
         end
      end
   end

   // Clear sweep FSM with registered status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_clr_reg  <= '0;
         r_clr_busy <= 1'b0;
         r_clr_done <= 1'b0;
         r_wr_ready <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (clr_req) begin
                  r_state    <= S_CLEAR;
                  r_clr_reg  <= clr_reg;
                  r_cnt      <= '0;
                  r_clr_busy <= 1'b1;
                  r_wr_ready <= 1'b0;
               end
            end
            S_CLEAR: begin
               if (r_cnt == ELE_AW'(NUM_ELE - 1)) begin
                  r_state    <= S_DONE;
                  r_cnt      <= '0;
                  r_clr_done <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + ELE_AW'(1);
               end
            end
            S_DONE: begin
               r_state    <= S_IDLE;
               r_clr_done <= 1'b0;
               r_clr_busy <= 1'b0;
               r_wr_ready <= 1'b1;
            end
            default: begin
               r_state    <= S_IDLE;
               r_cnt      <= '0;
               r_clr_done <= 1'b0;
               r_clr_busy <= 1'b0;
               r_wr_ready <= 1'b1;
            end
         endcase
      end
   end

   assign rd_data_a  = r_rd_data_a;
   assign rd_data_b  = r_rd_data_b;
   assign rd_valid_a = r_rd_valid_a;
   assign rd_valid_b = r_rd_valid_b;
   assign wr_ready   = r_wr_ready;
   assign clr_busy   = r_clr_busy;
   assign clr_done   = r_clr_done;

endmodule
